id_scanner: RTL and testbench

Parametrised identifier scanner: consumes one character per accepted beat and tracks whether the current run is a well-formed identifier, meaning a letter followed by any mix of letters and digits. It adds four things to the single-bit letter/digit recogniser: a valid qualifier, a length limit, a token-complete pulse with length, and a completed-identifier counter. It sits after the character source in the text-processing path and feeds token statistics downstream.

---
 rtl/id_scanner.sv | 140 ++++++++++++++
 tb/tb_id_scanner.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/id_scanner.sv
// id_scanner: character-stream identifier recogniser with length limit,
// token-complete pulse, last-token length and completed-identifier counter.
// Build option: define ID_UNDERSCORE_EN to treat '_' (0x5F) as a letter.
module id_scanner #(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 5,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [7:0]       char,
    output logic             in_id,
    output logic             match_num,
    output logic [LEN_W-1:0] tok_len,
    output logic             tok_done,
    output logic [LEN_W-1:0] last_len,
    output logic             too_long,
    output logic [CNT_W-1:0] id_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALPHA = 2'd1,
        DIGIT = 2'd2,
        SKIP  = 2'd3
    } state_t;

    localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);

    state_t             state;
    state_t             state_nx;
    logic               is_l;
    logic               is_d;
    logic [LEN_W-1:0]   len_nx;
    logic [LEN_W-1:0]   last_nx;
    logic [CNT_W-1:0]   cnt_nx;
    logic               done_nx;
    logic               too_nx;

    // Classify the incoming character as letter, digit or separator.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        is_l = 1'b0;
        is_d = 1'b0;
        if ((char >= 8'h41 && char <= 8'h5A) || (char >= 8'h61 && char <= 8'h7A))
            is_l = 1'b1;
`ifdef ID_UNDERSCORE_EN
        if (char == 8'h5F)
            is_l = 1'b1;
`else
        // '_' falls through as a separator in this build.
`endif
        if (char >= 8'h30 && char <= 8'h39)
            is_d = 1'b1;
    end

    // Next-state and next-output computation for one accepted beat.
    always_comb begin
        state_nx = state;
        len_nx   = tok_len;
        last_nx  = last_len;
        cnt_nx   = id_count;
        done_nx  = 1'b0;
        too_nx   = 1'b0;
        if (clear) begin
            state_nx = IDLE;
            len_nx   = '0;
            last_nx  = '0;
            cnt_nx   = '0;
        end else if (in_valid) begin
            unique case (state)
                IDLE: begin
                    if (is_l) begin
                        state_nx = ALPHA;
                        len_nx   = LEN_W'(1);
                    end else if (is_d) begin
                        // A digit cannot start an identifier.
                        state_nx = SKIP;
                        len_nx   = '0;
                    end
                end
                ALPHA, DIGIT: begin
                    if (is_l || is_d) begin
                        if (tok_len == MAX_LEN_V) begin
                            // Overlong run: drop it and ignore the rest of it.
                            state_nx = SKIP;
                            len_nx   = '0;
                            too_nx   = 1'b1;
                        end else begin
                            state_nx = is_l ? ALPHA : DIGIT;
                            len_nx   = tok_len + 1'b1;
                        end
                    end else begin
                        // Separator terminates a legal identifier.
                        state_nx = IDLE;
                        len_nx   = '0;
                        last_nx  = tok_len;
                        cnt_nx   = id_count + 1'b1;
                        done_nx  = 1'b1;
                    end
                end
                SKIP: begin
                    if (!(is_l || is_d))
                        state_nx = IDLE;
                    len_nx = '0;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Register state and every output so all outputs change just after the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_id     <= 1'b0;
            match_num <= 1'b0;
            tok_len   <= '0;
            tok_done  <= 1'b0;
            last_len  <= '0;
            too_long  <= 1'b0;
            id_count  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state     <= state_nx;
            in_id     <= (state_nx == ALPHA) || (state_nx == DIGIT);
            match_num <= (state_nx == DIGIT);
            tok_len   <= len_nx;
            tok_done  <= done_nx;
            last_len  <= last_nx;
            too_long  <= too_nx;
            id_count  <= cnt_nx;
        end
    end

endmodule

// File: tb/tb_id_scanner.sv
// Scoreboard bench for id_scanner (MAX_LEN=4, LEN_W=3, CNT_W=3 so the length
// limit and counter wrap are reached with short strings).
module tb_id_scanner;

    localparam int MAX_LEN = 4;
    localparam int LEN_W   = 3;
    localparam int CNT_W   = 3;

    logic             clk;
    logic             rst_n;
    logic             clear;
    logic             in_valid;
    logic [7:0]       char;
    logic             in_id;
    logic             match_num;
    logic [LEN_W-1:0] tok_len;
    logic             tok_done;
    logic [LEN_W-1:0] last_len;
    logic             too_long;
    logic [CNT_W-1:0] id_count;

    typedef struct packed {
        logic             in_id;
        logic             match_num;
        logic [LEN_W-1:0] tok_len;
        logic             tok_done;
        logic [LEN_W-1:0] last_len;
        logic             too_long;
        logic [CNT_W-1:0] id_count;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_vec;
    int    n_miss;

    id_scanner #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .in_valid (in_valid),
        .char     (char),
        .in_id    (in_id),
        .match_num(match_num),
        .tok_len  (tok_len),
        .tok_done (tok_done),
        .last_len (last_len),
        .too_long (too_long),
        .id_count (id_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare an observed output vector against the expected one.
    task automatic check(input string nm, input exp_t got, input exp_t want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got in_id=%0b match=%0b len=%0d done=%0b last=%0d too=%0b cnt=%0d, want in_id=%0b match=%0b len=%0d done=%0b last=%0d too=%0b cnt=%0d",
                     nm, got.in_id, got.match_num, got.tok_len, got.tok_done, got.last_len,
                     got.too_long, got.id_count, want.in_id, want.match_num, want.tok_len,
                     want.tok_done, want.last_len, want.too_long, want.id_count);
        end
    endtask

    // Monitor: after every rising edge, pop the next expectation and compare.
    always @(posedge clk) begin
        exp_t  want;
        exp_t  got;
        string nm;
        #1;
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            nm   = name_q.pop_front();
            got  = '{in_id, match_num, tok_len, tok_done, last_len, too_long, id_count};
            check(nm, got, want);
        end
    end

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    task automatic beat(input string nm, input logic rst, input logic clr, input logic v,
                        input logic [7:0] ch, input logic e_id, input logic e_m,
                        input int e_len, input logic e_done, input int e_last,
                        input logic e_too, input int e_cnt);
        exp_t e;
        @(negedge clk);
        rst_n    = rst;
        clear    = clr;
        in_valid = v;
        char     = ch;
        e = '{e_id, e_m, LEN_W'(e_len), e_done, LEN_W'(e_last), e_too, CNT_W'(e_cnt)};
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    initial begin
        n_vec    = 0;
        n_miss   = 0;
        rst_n    = 1'b0;
        clear    = 1'b0;
        in_valid = 1'b0;
        char     = 8'h00;

        beat("reset",      0, 0, 0, " ", 0, 0, 0, 0, 0, 0, 0);
        beat("idle",       1, 0, 0, " ", 0, 0, 0, 0, 0, 0, 0);

        // "ab12 " : also a separator at tok_len == MAX_LEN
        beat("ab12_a",     1, 0, 1, "a", 1, 0, 1, 0, 0, 0, 0);
        beat("ab12_b",     1, 0, 1, "b", 1, 0, 2, 0, 0, 0, 0);
        beat("ab12_1",     1, 0, 1, "1", 1, 1, 3, 0, 0, 0, 0);
        beat("ab12_2",     1, 0, 1, "2", 1, 1, 4, 0, 0, 0, 0);
        beat("ab12_sp",    1, 0, 1, " ", 0, 0, 0, 1, 4, 0, 1);

        // "9ab " stays in SKIP, then "x "
        beat("9ab_9",      1, 0, 1, "9", 0, 0, 0, 0, 4, 0, 1);
        beat("9ab_a",      1, 0, 1, "a", 0, 0, 0, 0, 4, 0, 1);
        beat("9ab_b",      1, 0, 1, "b", 0, 0, 0, 0, 4, 0, 1);
        beat("9ab_sp",     1, 0, 1, " ", 0, 0, 0, 0, 4, 0, 1);
        beat("x_x",        1, 0, 1, "x", 1, 0, 1, 0, 4, 0, 1);
        beat("x_sp",       1, 0, 1, " ", 0, 0, 0, 1, 1, 0, 2);

        // "abcde " overruns MAX_LEN=4
        beat("long_a",     1, 0, 1, "a", 1, 0, 1, 0, 1, 0, 2);
        beat("long_b",     1, 0, 1, "b", 1, 0, 2, 0, 1, 0, 2);
        beat("long_c",     1, 0, 1, "c", 1, 0, 3, 0, 1, 0, 2);
        beat("long_d",     1, 0, 1, "d", 1, 0, 4, 0, 1, 0, 2);
        beat("long_e",     1, 0, 1, "e", 0, 0, 0, 0, 1, 1, 2);
        beat("long_sp",    1, 0, 1, " ", 0, 0, 0, 0, 1, 0, 2);

        // "a1" with a 3-cycle in_valid gap
        beat("gap_a",      1, 0, 1, "a", 1, 0, 1, 0, 1, 0, 2);
        for (int i = 0; i < 3; i++)
            beat("gap_hold", 1, 0, 0, "7", 1, 0, 1, 0, 1, 0, 2);
        beat("gap_1",      1, 0, 1, "1", 1, 1, 2, 0, 1, 0, 2);
        beat("gap_sp",     1, 0, 1, " ", 0, 0, 0, 1, 2, 0, 3);

        // "z9q " : digit back to letter
        beat("z9q_z",      1, 0, 1, "z", 1, 0, 1, 0, 2, 0, 3);
        beat("z9q_9",      1, 0, 1, "9", 1, 1, 2, 0, 2, 0, 3);
        beat("z9q_q",      1, 0, 1, "q", 1, 0, 3, 0, 2, 0, 3);
        beat("z9q_sp",     1, 0, 1, "/", 0, 0, 0, 1, 3, 0, 4);

        // counter wrap 7 -> 0 with four "k " tokens
        for (int i = 0; i < 4; i++) begin
            beat("wrap_k",  1, 0, 1, "k", 1, 0, 1, 0, (i == 0) ? 3 : 1, 0, 4 + i);
            beat("wrap_sp", 1, 0, 1, ":", 0, 0, 0, 1, 1, 0, (5 + i) % 8);
        end

        // "Z@" : range-edge letter and separator
        beat("edge_Z",     1, 0, 1, "Z", 1, 0, 1, 0, 1, 0, 0);
        beat("edge_at",    1, 0, 1, "@", 0, 0, 0, 1, 1, 0, 1);

        // clear mid-token together with in_valid and '3'
        beat("clr_a",      1, 0, 1, "a", 1, 0, 1, 0, 1, 0, 1);
        beat("clr_b",      1, 0, 1, "b", 1, 0, 2, 0, 1, 0, 1);
        beat("clr_3",      1, 1, 1, "3", 0, 0, 0, 0, 0, 0, 0);

        // reset mid-token
        beat("rst_c",      1, 0, 1, "c", 1, 0, 1, 0, 0, 0, 0);
        beat("rst_mid",    0, 0, 1, "d", 0, 0, 0, 0, 0, 0, 0);
        beat("rst_rel",    1, 0, 0, " ", 0, 0, 0, 0, 0, 0, 0);

        // "a_b " : underscore handling depends on the build
        beat("us_a",       1, 0, 1, "a", 1, 0, 1, 0, 0, 0, 0);
`ifdef ID_UNDERSCORE_EN
        beat("us_us",      1, 0, 1, "_", 1, 0, 2, 0, 0, 0, 0);
        beat("us_b",       1, 0, 1, "b", 1, 0, 3, 0, 0, 0, 0);
        beat("us_sp",      1, 0, 1, " ", 0, 0, 0, 1, 3, 0, 1);
`else
        beat("us_us",      1, 0, 1, "_", 0, 0, 0, 1, 1, 0, 1);
        beat("us_b",       1, 0, 1, "b", 1, 0, 1, 0, 1, 0, 1);
        beat("us_sp",      1, 0, 1, " ", 0, 0, 0, 1, 1, 0, 2);
`endif
        beat("tail",       1, 0, 0, " ", 0, 0, 0, 0,
`ifdef ID_UNDERSCORE_EN
             3, 0, 1);
`else
             1, 0, 2);
`endif

        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
